// File: rtl/mem_access_ctrl.sv
// Memory access controller. Routes CPU word accesses to the scratchpad
// (single-cycle, combinational) or to the shared bus through a four-state
// request/grant/transfer handshake.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        as,
  input  logic        rw,
  input  logic [29:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        spm_as,
  output logic        spm_rw,
  output logic [11:0] spm_addr,
  output logic [31:0] spm_wr_data,
  input  logic [31:0] spm_rd_data,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic        bus_as,
  output logic        bus_rw,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy
);

  localparam int unsigned ADDR_W     = 30;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SPM_ADDR_W = 12;

  // Scratchpad window: upper three address bits select region 3.
  localparam logic [2:0] SPM_REGION = 3'b011;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] WAIT   = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] rd_buf;

  logic              spm_hit;
  logic              req_launch;
  logic              buf_load;
  logic [DATA_W-1:0] buf_nxt;

  assign spm_hit = (addr[29:27] == SPM_REGION);

  // Scratchpad address/data/direction pass straight through.
  assign spm_addr    = addr[SPM_ADDR_W-1:0];
  assign spm_wr_data = wr_data;
  assign spm_rw      = rw;

  // Next-state decode and all handshake outputs.
  always_comb begin
    state_nxt   = state;
    req_launch  = 1'b0;
    buf_load    = 1'b0;
    buf_nxt     = rd_buf;
    spm_as      = 1'b0;
    busy        = 1'b0;
    bus_req     = 1'b0;
    bus_as      = 1'b0;
    bus_rw      = 1'b0;
    bus_addr    = '0;
    bus_wr_data = '0;
    rd_data     = '0;

    if (!reset) begin
      case (state)
        IDLE: begin
          if (as && spm_hit) begin
            spm_as  = !flush;
            rd_data = spm_rd_data;
          end else if (as && !flush) begin
            req_launch = 1'b1;
            bus_req    = 1'b1;
            busy       = 1'b1;
            state_nxt  = REQ;
          end
        end
        REQ: begin
          bus_req = 1'b1;
          busy    = 1'b1;
          if (flush) begin
            state_nxt = IDLE;
          end else if (bus_grant) begin
            state_nxt = ACCESS;
          end
        end
        ACCESS: begin
          // Flush is deliberately ignored: a started bus transfer must finish.
          bus_as      = 1'b1;
          bus_rw      = rw_q;
          bus_addr    = addr_q;
          bus_wr_data = wr_data_q;
          bus_req     = !bus_rdy;
          busy        = !bus_rdy;
          if (bus_rdy) begin
            rd_data   = bus_rd_data;
            buf_load  = 1'b1;
            buf_nxt   = rw_q ? DATA_W'(0) : bus_rd_data;
            state_nxt = stall ? WAIT : IDLE;
          end
        end
        WAIT: begin
          rd_data = rd_buf;
          if (!stall) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State register; reset abandons any in-flight transfer immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request capture and read-data holding buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wr_data_q <= '0;
      rd_buf    <= '0;
    end else begin
      if (req_launch) begin
        addr_q    <= addr;
        rw_q      <= rw;
        wr_data_q <= wr_data;
      end
      if (buf_load) begin
        rd_buf <= buf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared against a transaction model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset, stall, flush, as, rw;
  logic [29:0] addr;
  logic [31:0] wr_data, rd_data;
  logic        busy, spm_as, spm_rw;
  logic [11:0] spm_addr;
  logic [31:0] spm_wr_data, spm_rd_data;
  logic        bus_req, bus_grant, bus_as, bus_rw;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_data, bus_rd_data;
  logic        bus_rdy;

  int n_total = 0;
  int n_pass  = 0;

  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .as(as), .rw(rw),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .busy(busy),
    .spm_as(spm_as), .spm_rw(spm_rw), .spm_addr(spm_addr),
    .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data),
    .bus_req(bus_req), .bus_grant(bus_grant), .bus_as(bus_as),
    .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy(bus_rdy)
  );

  always #5 clk = ~clk;

  // Transaction model: a bus request is either waiting for grant, on the
  // bus, or finished and holding its read data while the pipeline stalls.
  bit          m_waiting_grant, m_on_bus, m_holding;
  logic [29:0] m_addr;
  logic        m_rw;
  logic [31:0] m_wd, m_held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic set_idle_inputs();
    reset = 1'b0; stall = 1'b0; flush = 1'b0; as = 1'b0; rw = 1'b0;
    addr = '0; wr_data = '0; spm_rd_data = '0; bus_grant = 1'b0;
    bus_rd_data = '0; bus_rdy = 1'b0;
  endtask

  // Settle combinational outputs and compare every output against the model.
  task automatic settle_check();
    bit          free, hit, spm_sel, launch, xfer_done;
    logic [31:0] e_rd;
    #2;
    free      = !m_waiting_grant && !m_on_bus && !m_holding;
    hit       = (addr >> 27) == 30'd3;
    spm_sel   = !reset && free && as && hit;
    launch    = !reset && free && as && !hit && !flush;
    xfer_done = !reset && m_on_bus && bus_rdy;
    if (spm_sel)               e_rd = spm_rd_data;
    else if (xfer_done)        e_rd = bus_rd_data;
    else if (!reset && m_holding) e_rd = m_held;
    else                       e_rd = 32'h0;
    chk("spm_addr",    32'(spm_addr), 32'(addr % 4096));
    chk("spm_wr_data", spm_wr_data, wr_data);
    chk("spm_rw",      32'(spm_rw), 32'(rw));
    chk("spm_as",      32'(spm_as), 32'(spm_sel && !flush));
    chk("rd_data",     rd_data, e_rd);
    chk("busy",        32'(busy),
        32'(launch || (!reset && (m_waiting_grant || (m_on_bus && !bus_rdy)))));
    chk("bus_req",     32'(bus_req),
        32'(launch || (!reset && (m_waiting_grant || (m_on_bus && !bus_rdy)))));
    chk("bus_as",      32'(bus_as), 32'(!reset && m_on_bus));
    chk("bus_rw",      32'(bus_rw), 32'(!reset && m_on_bus && m_rw));
    chk("bus_addr",    32'(bus_addr), (!reset && m_on_bus) ? 32'(m_addr) : 32'h0);
    chk("bus_wr_data", bus_wr_data, (!reset && m_on_bus) ? m_wd : 32'h0);
  endtask

  // Clock edge, then advance the model with the inputs that were sampled.
  task automatic advance();
    bit free, hit;
    @(posedge clk);
    free = !m_waiting_grant && !m_on_bus && !m_holding;
    hit  = (addr >> 27) == 30'd3;
    if (reset) begin
      m_waiting_grant = 0; m_on_bus = 0; m_holding = 0;
      m_addr = '0; m_rw = 0; m_wd = '0; m_held = '0;
    end else if (free) begin
      if (as && !hit && !flush) begin
        m_waiting_grant = 1; m_addr = addr; m_rw = rw; m_wd = wr_data;
      end
    end else if (m_waiting_grant) begin
      if (flush) m_waiting_grant = 0;
      else if (bus_grant) begin m_waiting_grant = 0; m_on_bus = 1; end
    end else if (m_on_bus) begin
      if (bus_rdy) begin
        m_on_bus  = 0;
        m_held    = m_rw ? 32'h0 : bus_rd_data;
        m_holding = stall;
      end
    end else if (m_holding && !stall) begin
      m_holding = 0;
    end
    #1;
  endtask

  task automatic cycle();
    settle_check();
    advance();
  endtask

  int busy_cnt, as_cnt, wait_cnt;

  initial begin
    set_idle_inputs();
    m_waiting_grant = 0; m_on_bus = 0; m_holding = 0;
    m_addr = '0; m_rw = 0; m_wd = '0; m_held = '0;
    #1;

    // Reset with an active SPM-hit request on the inputs: all strobes held low.
    reset = 1'b1; as = 1'b1; addr = 30'h1800_0004; spm_rd_data = 32'h1111_2222;
    settle_check();
    chk("reset_spm_as", 32'(spm_as), 32'h0);
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    advance();
    advance();
    set_idle_inputs();

    // SPM read, single cycle.
    as = 1'b1; rw = 1'b0; addr = 30'h1800_0004; spm_rd_data = 32'hCAFE_0001;
    settle_check();
    chk("spm_rd_as", 32'(spm_as), 32'h1);
    chk("spm_rd_addr", 32'(spm_addr), 32'h004);
    chk("spm_rd_data", rd_data, 32'hCAFE_0001);
    chk("spm_rd_busy", 32'(busy), 32'h0);
    advance();

    // SPM write, single cycle, no bus activity.
    set_idle_inputs();
    as = 1'b1; rw = 1'b1; addr = 30'h1800_0010; wr_data = 32'h1234_5678;
    settle_check();
    chk("spm_wr_as", 32'(spm_as), 32'h1);
    chk("spm_wr_rw", 32'(spm_rw), 32'h1);
    chk("spm_wr_wd", spm_wr_data, 32'h1234_5678);
    chk("spm_wr_bus_req", 32'(bus_req), 32'h0);
    advance();

    // Bus read: grant on second REQ cycle, rdy on fourth ACCESS cycle.
    busy_cnt = 0; as_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      set_idle_inputs();
      if (i == 0) begin as = 1'b1; addr = 30'h0000_0040; end
      if (i == 2) bus_grant = 1'b1;
      if (i == 6) begin bus_rdy = 1'b1; bus_rd_data = 32'hDEAD_BEEF; end
      settle_check();
      if (busy) busy_cnt++;
      if (bus_as) as_cnt++;
      if (i == 6) chk("bus_rd_data_rdy", rd_data, 32'hDEAD_BEEF);
      if (i == 3) chk("bus_rd_addr", 32'(bus_addr), 32'h40);
      advance();
    end
    chk("bus_rd_busy_cycles", 32'(busy_cnt), 32'd6);
    chk("bus_rd_as_cycles", 32'(as_cnt), 32'd4);
    set_idle_inputs();
    settle_check();
    chk("bus_rd_back_idle_req", 32'(bus_req), 32'h0);
    chk("bus_rd_back_idle_rd", rd_data, 32'h0);
    advance();

    // Bus read completing under stall: held data presented in WAIT.
    wait_cnt = 0;
    set_idle_inputs(); as = 1'b1; addr = 30'h0000_0100; cycle();
    set_idle_inputs(); bus_grant = 1'b1; cycle();
    set_idle_inputs(); bus_rdy = 1'b1; bus_rd_data = 32'h5555_AAAA; stall = 1'b1; cycle();
    for (int i = 0; i < 3; i++) begin
      set_idle_inputs(); stall = (i < 2); bus_rd_data = 32'h0BAD_0BAD;
      settle_check();
      if (!busy && rd_data == 32'h5555_AAAA) wait_cnt++;
      advance();
    end
    chk("wait_cycles", 32'(wait_cnt), 32'd3);
    set_idle_inputs();
    settle_check();
    chk("wait_back_idle_rd", rd_data, 32'h0);
    advance();

    // Flush while waiting for grant cancels the request.
    as_cnt = 0;
    set_idle_inputs(); as = 1'b1; addr = 30'h0000_0200; cycle();
    set_idle_inputs(); flush = 1'b1; bus_grant = 1'b1;
    settle_check(); if (bus_as) as_cnt++; advance();
    set_idle_inputs(); bus_grant = 1'b1;
    settle_check(); if (bus_as) as_cnt++;
    chk("flush_req_dropped", 32'(bus_req), 32'h0);
    chk("flush_busy", 32'(busy), 32'h0);
    advance();
    chk("flush_no_bus_as", 32'(as_cnt), 32'h0);

    // Reset mid-ACCESS abandons the transfer.
    set_idle_inputs(); as = 1'b1; rw = 1'b1; addr = 30'h0000_0300; wr_data = 32'hFEED_F00D; cycle();
    set_idle_inputs(); bus_grant = 1'b1; cycle();
    set_idle_inputs(); settle_check();
    chk("acc_bus_wr_data", bus_wr_data, 32'hFEED_F00D);
    advance();
    set_idle_inputs(); reset = 1'b1; cycle();
    set_idle_inputs(); settle_check();
    chk("rst_acc_bus_req", 32'(bus_req), 32'h0);
    chk("rst_acc_bus_as", 32'(bus_as), 32'h0);
    chk("rst_acc_busy", 32'(busy), 32'h0);
    chk("rst_acc_rd_data", rd_data, 32'h0);
    advance();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 59) == 0);
      stall       = ($urandom_range(0, 2) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      as          = $urandom_range(0, 1) == 1;
      rw          = $urandom_range(0, 1) == 1;
      addr        = 30'($urandom);
      if ($urandom_range(0, 1) == 1) addr[29:27] = 3'b011;
      wr_data     = $urandom;
      spm_rd_data = $urandom;
      bus_rd_data = $urandom;
      bus_grant   = ($urandom_range(0, 2) == 0);
      bus_rdy     = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
